// File: rtl/rtc_time_set_ctrl_if.sv
// rtl/rtc_time_set_ctrl_if.sv - panel/counter signal bundle for the RTC time-set controller
//   btn_mode/btn_inc : raw active-high panel buttons (asynchronous to clk)
//   tick_1hz         : one-clk pulse per second
//   cur_*            : live BCD time from the digit counters
//   set_*            : shadow BCD time to be loaded into the counters
//   load/run_en      : counter control (load strobe, advance enable)
//   blank/state_o    : display blink mask {hr,min,sec} and FSM state encoding
interface rtc_time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       tick_1hz;
    logic [3:0] cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl;
    logic [3:0] set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl;
    logic       load;
    logic       run_en;
    logic [2:0] blank;
    logic [2:0] state_o;

    // master: panel/counter side driving the controller
    modport master (
        output btn_mode, btn_inc, tick_1hz,
        output cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl,
        input  set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl,
        input  load, run_en, blank, state_o
    );

    // slave: the controller itself
    modport slave (
        input  btn_mode, btn_inc, tick_1hz,
        input  cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl,
        output set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl,
        output load, run_en, blank, state_o
    );
endinterface

// File: rtl/rtc_time_set_ctrl.sv
// rtl/rtc_time_set_ctrl.sv - MODE/INC front-panel run/set sequencer for a BCD hh:mm:ss clock
//   clk : system clock (posedge)
//   rst : asynchronous active-low reset
//   bus : rtc_time_set_ctrl_if.slave (buttons, tick, cur_*, set_*, load, run_en, blank, state_o)
module rtc_time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_TICKS   = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    rtc_time_set_ctrl_if.slave   bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        SET_SEC = 3'd3,
        COMMIT  = 3'd4
    } state_t;

    // Button index 0 = MODE, 1 = INC
    logic [1:0]    raw;
    logic [1:0]    sync1_q, sync2_q, level_q, press_q;
    logic [CW-1:0] cnt_q [2];

    assign raw = {bus.btn_inc, bus.btn_mode};

    // Level only flips after DEBOUNCE_CYCLES consecutive synchronised samples
    // that disagree with it; the press pulse fires on the 0->1 flip itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_q[i]   <= '0;
                    press_q[i] <= 1'b0;
                end else if (cnt_q[i] == DB_LAST) begin
                    cnt_q[i]   <= '0;
                    level_q[i] <= sync2_q[i];
                    press_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i]   <= cnt_q[i] + 1'b1;
                    press_q[i] <= 1'b0;
                end
            end
        end
    end

    logic mode_p, inc_p;
    assign mode_p = press_q[0];
    assign inc_p  = press_q[1];

    state_t        state_q, state_d;
    logic [3:0]    hrm_q, hrl_q, minm_q, minl_q, secm_q, secl_q;
    logic [3:0]    hrm_d, hrl_d, minm_d, minl_d, secm_d, secl_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          blink_q, blink_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            hrm_q   <= '0; hrl_q  <= '0;
            minm_q  <= '0; minl_q <= '0;
            secm_q  <= '0; secl_q <= '0;
            tmo_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hrm_q   <= hrm_d;  hrl_q  <= hrl_d;
            minm_q  <= minm_d; minl_q <= minl_d;
            secm_q  <= secm_d; secl_q <= secl_d;
            tmo_q   <= tmo_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hrm_d   = hrm_q;  hrl_d  = hrl_q;
        minm_d  = minm_q; minl_d = minl_q;
        secm_d  = secm_q; secl_d = secl_q;
        tmo_d   = tmo_q;
        blink_d = blink_q;
        case (state_q)
            RUN: begin
                tmo_d   = '0;
                blink_d = 1'b0;
                if (mode_p) begin
                    hrm_d  = bus.cur_hrm;  hrl_d  = bus.cur_hrl;
                    minm_d = bus.cur_minm; minl_d = bus.cur_minl;
                    secm_d = bus.cur_secm; secl_d = bus.cur_secl;
                    state_d = SET_HR;
                end
            end
            SET_HR, SET_MIN, SET_SEC: begin
                if (mode_p) begin
                    // mode wins over a coincident inc press
                    state_d = (state_q == SET_HR)  ? SET_MIN :
                              (state_q == SET_MIN) ? SET_SEC : COMMIT;
                    tmo_d   = '0;
                    blink_d = 1'b0;
                end else begin
                    if (inc_p) begin
                        tmo_d = '0;
                        if (state_q == SET_HR) begin
                            if (hrm_q == 4'd2 && hrl_q == 4'd3) begin
                                hrm_d = 4'd0; hrl_d = 4'd0;
                            end else if (hrl_q == 4'd9) begin
                                hrl_d = 4'd0; hrm_d = hrm_q + 4'd1;
                            end else begin
                                hrl_d = hrl_q + 4'd1;
                            end
                        end else if (state_q == SET_MIN) begin
                            if (minl_q == 4'd9) begin
                                minl_d = 4'd0;
                                minm_d = (minm_q == 4'd5) ? 4'd0 : minm_q + 4'd1;
                            end else begin
                                minl_d = minl_q + 4'd1;
                            end
                        end else begin
                            if (secl_q == 4'd9) begin
                                secl_d = 4'd0;
                                secm_d = (secm_q == 4'd5) ? 4'd0 : secm_q + 4'd1;
                            end else begin
                                secl_d = secl_q + 4'd1;
                            end
                        end
                    end else if (bus.tick_1hz) begin
                        if (tmo_q == TMO_LAST) begin
                            // abandon the edit; counters simply resume
                            state_d = RUN;
                            tmo_d   = '0;
                        end else begin
                            tmo_d = tmo_q + 1'b1;
                        end
                    end
                    if (state_d != state_q) blink_d = 1'b0;
                    else if (bus.tick_1hz)  blink_d = ~blink_q;
                end
            end
            COMMIT: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.set_hrm  = hrm_q;
    assign bus.set_hrl  = hrl_q;
    assign bus.set_minm = minm_q;
    assign bus.set_minl = minl_q;
    assign bus.set_secm = secm_q;
    assign bus.set_secl = secl_q;
    assign bus.load     = (state_q == COMMIT);
    assign bus.run_en   = (state_q == RUN);
    assign bus.blank    = {(state_q == SET_HR)  && blink_q,
                           (state_q == SET_MIN) && blink_q,
                           (state_q == SET_SEC) && blink_q};
    assign bus.state_o  = state_q;
endmodule
